clock_divider_prog: RTL

Programmable successor to the fixed 1/8 clock divider. It generates a divided clock `Out_clk` from `In_clk` with a divide ratio and high time that can be changed at run time, plus a one-cycle `tick` strobe usable as a clock enable in the `In_clk` domain. It sits between the board clock and the processor core and peripherals. A new ratio takes effect glitch-free at the next period boundary.

---
 rtl/clock_divider_prog.sv | 117 +++++++++++
 1 files changed

// File: rtl/clock_divider_prog.sv
// Programmable clock divider: divides In_clk by a run-time period P with high
// time H. The Out_clk and tick outputs are registered. A new P/H is held in
// shadow registers and switched in only at a period boundary, so the output
// never shows a runt pulse.
module clock_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             In_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             Out_clk,
    output logic             tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV / 2);

    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] per_q,     per_d;
    logic [WIDTH-1:0] high_q,    high_d;
    logic [WIDTH-1:0] sh_per_q,  sh_per_d;
    logic [WIDTH-1:0] sh_high_q, sh_high_d;
    logic             pend_q,    pend_d;
    logic             out_q,     out_d;
    logic             tick_q,    tick_d;

    logic [WIDTH-1:0] cnt_inc;
    logic             at_end;
    logic [WIDTH-1:0] new_per;
    logic [WIDTH-1:0] new_high;

    // The period must be at least 2 so that there is both a high and a low phase.
    function automatic logic [WIDTH-1:0] clamp_per(input logic [WIDTH-1:0] p);
        return (p < WIDTH'(2)) ? WIDTH'(2) : p;
    endfunction

    // The high time lies in 1..P-1. P must already be clamped.
    function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] h);
        logic [WIDTH-1:0] hh;
        hh = (h == '0) ? WIDTH'(1) : h;
        if (hh >= p) hh = p - WIDTH'(1);
        return hh;
    endfunction

    // cnt never exceeds P-1 <= 2^WIDTH-2, so cnt+1 cannot wrap.
    assign cnt_inc  = cnt_q + WIDTH'(1);
    assign at_end   = (cnt_q == per_q - WIDTH'(1));
    assign new_per  = clamp_per(sh_per_q);
    assign new_high = clamp_high(new_per, sh_high_q);

    // Next-state logic: advance the counter, apply the shadow at boundaries, capture loads.
    always_comb begin
        cnt_d     = cnt_q;
        per_d     = per_q;
        high_d    = high_q;
        sh_per_d  = sh_per_q;
        sh_high_d = sh_high_q;
        pend_d    = pend_q;
        out_d     = out_q;
        tick_d    = 1'b0;
        if (en) begin
            if (at_end) begin
                cnt_d  = '0;
                out_d  = 1'b1;
                tick_d = 1'b1;
                if (pend_q) begin
                    per_d  = new_per;
                    high_d = new_high;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_inc;
                out_d = (cnt_inc < high_q);
            end
        end
        // A load on a boundary edge is applied at the next boundary, not this one.
        if (load) begin
            sh_per_d  = div_in;
            sh_high_d = high_in;
            pend_d    = 1'b1;
        end
    end

    // State registers. Reset discards any pending configuration.
    always_ff @(posedge In_clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= DEF_P - WIDTH'(1);
            per_q     <= DEF_P;
            high_q    <= DEF_H;
            sh_per_q  <= '0;
            sh_high_q <= '0;
            pend_q    <= 1'b0;
            out_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            high_q    <= high_d;
            sh_per_q  <= sh_per_d;
            sh_high_q <= sh_high_d;
            pend_q    <= pend_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
        end
    end

    assign Out_clk = out_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule
